// File: rtl/host_cmd_deframer_pkg.sv
// rtl/host_cmd_deframer_pkg.sv - shared states and constants for host_cmd_deframer
// Purpose: the deframer state enumeration, the default frame start marker and
//          the write opcode. This package has no ports.
// Optional feature macro: CMD_CHECKSUM_EN (adds the ST_CHK state).
package host_cmd_deframer_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hCD;
  localparam logic [3:0] WR_OPCODE         = 4'h1;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_ISSUE_HDR,
    ST_PAYLOAD,
    ST_ISSUE_WORD
`ifdef CMD_CHECKSUM_EN
    , ST_CHK
`endif
  } state_e;

  // The opcode lives in the low nibble of the command word.
  function automatic logic is_write_cmd(input logic [3:0] opcode);
    return opcode == WR_OPCODE;
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - shifts bytes MSB-first into a 32-bit word
// Purpose: collects four bytes into a big-endian word; shared by the header
//          and the payload phases of host_cmd_deframer.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clear       drop any partial word and restart at byte 0
//   byte_valid  byte_in is consumed this cycle
//   byte_in     incoming byte
//   word        the completed word; meaningful in the cycle done is high
//   done        high on the 4th consumed byte
module byte_word_assembler
  import host_cmd_deframer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        done
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = cnt_q + 2'd1;   // wraps to 0 after the 4th byte
    end
  end

  // The 4th byte is combined in directly so the word is usable the cycle it lands.
  assign word = {shift_q, byte_in};
  assign done = byte_valid && !clear && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/host_cmd_deframer.sv
// rtl/host_cmd_deframer.sv - host byte stream to wishbone-master command deframer
// Purpose: finds SYNC_BYTE, assembles command/address/data words, strobes them
//          to the master, then streams write payload words one at a time.
// Optional feature macro: CMD_CHECKSUM_EN (XOR check byte after the header).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   rx_byte, rx_valid, rx_ready       host byte input handshake
//   master_ready                      master can take a word
//   in_ready                          one-cycle strobe, words below valid
//   in_command, in_address, in_data   words presented to the master
//   frame_err                         one-cycle pulse on an aborted frame
//   busy                              high whenever not hunting for sync
module host_cmd_deframer
  import host_cmd_deframer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        master_ready,
  output logic        in_ready,
  output logic [31:0] in_command,
  output logic [31:0] in_address,
  output logic [31:0] in_data,
  output logic        frame_err,
  output logic        busy
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [27:0] cnt_q, cnt_d;
  logic [31:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic        in_ready_q, in_ready_d;
  logic        frame_err_q, frame_err_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic        accept, counting, timeout;
  logic        asm_clear, asm_valid, asm_done;
  logic [31:0] asm_word;

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_byte),
    .word       (asm_word),
    .done       (asm_done)
  );

  assign rx_ready = (state_q != ST_ISSUE_HDR) && (state_q != ST_ISSUE_WORD);
  assign accept   = rx_valid && rx_ready;
  // Only byte-gathering states can time out; issue states wait forever.
  assign counting = rx_ready && (state_q != ST_HUNT);
  assign timeout  = counting && !accept && (idle_q == IW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    idle_d      = '0;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    in_ready_d  = 1'b0;
    frame_err_d = 1'b0;
    asm_clear   = 1'b0;
    asm_valid   = 1'b0;
`ifdef CMD_CHECKSUM_EN
    chk_d       = chk_q;
`endif

    if (counting) idle_d = accept ? '0 : idle_q + IW'(1);

    case (state_q)
      ST_HUNT: begin
        asm_clear = 1'b1;
`ifdef CMD_CHECKSUM_EN
        chk_d = '0;
`endif
        if (accept && rx_byte == SYNC_BYTE) state_d = ST_CMD;
      end
      ST_CMD, ST_ADDR, ST_DATA: begin
        asm_valid = accept;
`ifdef CMD_CHECKSUM_EN
        if (accept) chk_d = chk_q ^ rx_byte;
`endif
        if (asm_done) begin
          if (state_q == ST_CMD) begin
            cmd_d   = asm_word;
            state_d = ST_ADDR;
          end else if (state_q == ST_ADDR) begin
            addr_d  = asm_word;
            state_d = ST_DATA;
          end else begin
            data_d  = asm_word;
`ifdef CMD_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_ISSUE_HDR;
`endif
          end
        end
      end
`ifdef CMD_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          if (rx_byte == chk_q) begin
            state_d = ST_ISSUE_HDR;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
          end
        end
      end
`endif
      ST_ISSUE_HDR: begin
        if (master_ready) begin
          in_ready_d = 1'b1;
          if (is_write_cmd(cmd_q[3:0]) && data_q[27:0] != '0) begin
            cnt_d   = data_q[27:0];
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_PAYLOAD: begin
        asm_valid = accept;
        if (asm_done) begin
          data_d  = asm_word;
          state_d = ST_ISSUE_WORD;
        end
      end
      ST_ISSUE_WORD: begin
        if (master_ready) begin
          in_ready_d = 1'b1;
          cnt_d      = cnt_q - 28'd1;
          state_d    = (cnt_q == 28'd1) ? ST_HUNT : ST_PAYLOAD;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if (timeout) begin
      state_d     = ST_HUNT;
      frame_err_d = 1'b1;
      asm_clear   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      idle_q      <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      frame_err_q <= frame_err_d;
`ifdef CMD_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign frame_err  = frame_err_q;
  assign in_command = cmd_q;
  assign in_address = addr_q;
  assign in_data    = data_q;
  assign busy       = (state_q != ST_HUNT);

endmodule

// File: tb/tb_host_cmd_deframer.sv
// tb/tb_host_cmd_deframer.sv - scoreboard testbench for host_cmd_deframer
module tb_host_cmd_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        master_ready = 1'b1;
  logic        in_ready;
  logic [31:0] in_command, in_address, in_data;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobe = 0;
  int n_ferr   = 0;
  logic prev_in_ready = 1'b0;
  logic [95:0] exp_q[$];

  always #5 clk = ~clk;

  host_cmd_deframer dut (
    .clk          (clk),
    .rst          (rst),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .master_ready (master_ready),
    .in_ready     (in_ready),
    .in_command   (in_command),
    .in_address   (in_address),
    .in_data      (in_data),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, counts frame_err pulses.
  always @(negedge clk) begin
    if (in_ready) begin
      n_strobe++;
      check_eq("in_ready_back_to_back", {31'd0, prev_in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        check_eq("in_command", in_command, e[95:64]);
        check_eq("in_address", in_address, e[63:32]);
        check_eq("in_data", in_data, e[31:0]);
      end
    end
    if (frame_err) n_ferr++;
    prev_in_ready = in_ready;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check_eq("rx_ready_wait_expired", 32'd0, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_frame(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                            input logic corrupt, input logic expect_strobe);
    logic [95:0] hdr;
    logic [7:0]  x;
    hdr = {c, a, d};
    x = '0;
    for (int i = 0; i < 12; i++) x = x ^ hdr[i*8 +: 8];
    if (expect_strobe) exp_q.push_back(hdr);
    send_byte(8'hCD);
    send_word(c);
    send_word(a);
    send_word(d);
`ifdef CMD_CHECKSUM_EN
    send_byte(corrupt ? ~x : x);
`else
    if (corrupt) x = 8'h00;
`endif
  endtask

  task automatic send_payload(input logic [31:0] c, input logic [31:0] a, input logic [31:0] w);
    exp_q.push_back({c, a, w});
    send_word(w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int s0, f0, lowcnt, waitn;

  initial begin
    repeat (3) @(negedge clk);
    // reset state, sampled while rst is still asserted
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check_eq("rst_in_command", in_command, 32'd0);
    check_eq("rst_in_address", in_address, 32'd0);
    check_eq("rst_in_data", in_data, 32'd0);
    rst = 1'b0;
    idle(2);

    // read frame
    s0 = n_strobe;
    send_frame(32'h0000_0000, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b1);
    idle(5);
    check_eq("read_strobes", n_strobe - s0, 32'd1);
    check_eq("read_busy_after", {31'd0, busy}, 32'd0);

    // write frame, two payload words
    s0 = n_strobe;
    send_frame(32'h0000_0001, 32'h0000_0200, 32'h0000_0002, 1'b0, 1'b1);
    send_payload(32'h0000_0001, 32'h0000_0200, 32'hDEAD_BEEF);
    send_payload(32'h0000_0001, 32'h0000_0200, 32'h1234_5678);
    idle(5);
    check_eq("write_strobes", n_strobe - s0, 32'd3);
    check_eq("write_busy_after", {31'd0, busy}, 32'd0);

    // same write with master_ready stalled 50 cycles before each word
    s0 = n_strobe;
    f0 = n_ferr;
    master_ready = 1'b0;
    fork
      begin
        send_frame(32'h0000_0001, 32'h0000_0200, 32'h0000_0002, 1'b0, 1'b1);
        send_payload(32'h0000_0001, 32'h0000_0200, 32'hDEAD_BEEF);
        send_payload(32'h0000_0001, 32'h0000_0200, 32'h1234_5678);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          waitn = 0;
          while (!(busy && !rx_ready) && waitn < 2000) begin
            @(negedge clk);
            waitn++;
          end
          check_eq("stall_reached_issue", {31'd0, busy && !rx_ready}, 32'd1);
          lowcnt = 0;
          repeat (50) begin
            @(negedge clk);
            if (!rx_ready && !in_ready) lowcnt++;
          end
          check_eq("stall_rx_ready_low", lowcnt, 32'd50);
          master_ready = 1'b1;
          waitn = 0;
          while (!in_ready && waitn < 100) begin
            @(negedge clk);
            waitn++;
          end
          check_eq("stall_strobe_seen", {31'd0, in_ready}, 32'd1);
          master_ready = 1'b0;
        end
      end
    join
    master_ready = 1'b1;
    idle(5);
    check_eq("stall_strobes", n_strobe - s0, 32'd3);
    check_eq("stall_no_frame_err", n_ferr - f0, 32'd0);

    // leading garbage, then a read whose address contains the sync byte
    s0 = n_strobe;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_frame(32'h0000_0010, 32'hCDCD_CDCD, 32'h0000_00CD, 1'b0, 1'b1);
    idle(5);
    check_eq("garbage_strobes", n_strobe - s0, 32'd1);

    // write with zero count, and a non-write opcode carrying a count
    s0 = n_strobe;
    send_frame(32'h0000_0001, 32'h0000_0300, 32'h0000_0000, 1'b0, 1'b1);
    idle(3);
    check_eq("zero_count_busy", {31'd0, busy}, 32'd0);
    send_frame(32'h0000_00F2, 32'h0000_0400, 32'h0000_0005, 1'b0, 1'b1);
    idle(3);
    check_eq("other_cmd_busy", {31'd0, busy}, 32'd0);
    check_eq("zero_other_strobes", n_strobe - s0, 32'd2);

    // header stalled after 6 bytes -> inter-byte timeout
    s0 = n_strobe;
    f0 = n_ferr;
    send_byte(8'hCD);
    send_word(32'h0000_0000);
    send_byte(8'h00);
    idle(1000);
    check_eq("timeout_not_early", n_ferr - f0, 32'd0);
    check_eq("timeout_busy_before", {31'd0, busy}, 32'd1);
    idle(100);
    check_eq("timeout_frame_err", n_ferr - f0, 32'd1);
    check_eq("timeout_busy_after", {31'd0, busy}, 32'd0);
    check_eq("timeout_no_strobe", n_strobe - s0, 32'd0);
    send_frame(32'h0000_0000, 32'h0000_0500, 32'h0000_0000, 1'b0, 1'b1);
    idle(5);
    check_eq("after_timeout_strobes", n_strobe - s0, 32'd1);

`ifdef CMD_CHECKSUM_EN
    // corrupted check byte
    s0 = n_strobe;
    f0 = n_ferr;
    send_frame(32'h0000_0000, 32'h0000_0600, 32'h0000_0000, 1'b1, 1'b0);
    idle(5);
    check_eq("chk_bad_frame_err", n_ferr - f0, 32'd1);
    check_eq("chk_bad_no_strobe", n_strobe - s0, 32'd0);
`endif

    // reset in the middle of a payload word
    s0 = n_strobe;
    f0 = n_ferr;
    send_frame(32'h0000_0001, 32'h0000_0700, 32'h0000_0002, 1'b0, 1'b1);
    send_payload(32'h0000_0001, 32'h0000_0700, 32'hCAFE_F00D);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(5);
    check_eq("rst_mid_strobes", n_strobe - s0, 32'd2);
    check_eq("rst_mid_no_frame_err", n_ferr - f0, 32'd0);
    check_eq("rst_mid_in_data", in_data, 32'd0);

    check_eq("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
